// File: rtl/unified_mem_resp_if.sv
// ---------------------------------------------------------------------------
// unified_mem_resp_if
//   Cache-controller <-> unified main memory block transfer bus.
//   master : the cache controller (drives addr/re/we/wdata, sees rdata/rdy)
//   slave  : the memory responder (unified_mem_resp)
//   Signals:
//     addr  [ADDR_W-1:0] block address (word address [15:2])
//     re / we            read / write request levels
//     wdata [63:0]       write block, word 0 in [15:0], word 3 in [63:48]
//     rdata [63:0]       registered read block
//     rdy                one-cycle completion strobe
// ---------------------------------------------------------------------------
interface unified_mem_resp_if #(
  parameter int ADDR_W = 14
);
  logic [ADDR_W-1:0] addr;
  logic              re;
  logic              we;
  logic [63:0]       wdata;
  logic [63:0]       rdata;
  logic              rdy;

  modport master (
    output addr, re, we, wdata,
    input  rdata, rdy
  );

  modport slave (
    input  addr, re, we, wdata,
    output rdata, rdy
  );
endinterface

// File: rtl/unified_mem_resp.sv
// ---------------------------------------------------------------------------
// unified_mem_resp
//   Multi-cycle unified (instruction + data) main memory answering 4-word
//   (64-bit) block read/write requests from the cache controller after a
//   fixed latency. Flow per request: IDLE -> BUSY (LATENCY cycles) -> DONE
//   (rdy high for one cycle) -> IDLE.
//
//   Parameters:
//     ADDR_W  : block address width; 2^ADDR_W blocks of 4 x 16-bit words
//     LATENCY : BUSY cycles per request, 1..15
//   Ports:
//     clk    : system clock, rising edge
//     rst_n  : asynchronous active-low reset
//     bus    : unified_mem_resp_if.slave (addr, re, we, wdata, rdata, rdy)
//     err    : sticky protocol error flag (only with UMEM_ERR_EN)
//
//   Build option: define UMEM_ERR_EN to add the err port and its checker.
//   The memory array itself is never reset; contents survive rst_n.
// ---------------------------------------------------------------------------
module unified_mem_resp #(
  parameter int ADDR_W  = 14,
  parameter int LATENCY = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  unified_mem_resp_if.slave       bus
`ifdef UMEM_ERR_EN
  ,
  output logic                    err
`endif
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              rdy_q, rdy_d;
  logic [63:0]       rdata_q, rdata_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              op_q, op_d;        // 1 = WRITE, 0 = READ
  logic [63:0]       wdata_q, wdata_d;
  logic              mem_we;

  logic [63:0]       mem [2**ADDR_W];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdy_d   = 1'b0;
    rdata_d = rdata_q;
    addr_d  = addr_q;
    op_d    = op_q;
    wdata_d = wdata_q;
    mem_we  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.re || bus.we) begin
          addr_d  = bus.addr;
          wdata_d = bus.wdata;
          op_d    = bus.we;               // write wins when both are high
          cnt_d   = 4'(LATENCY - 1);
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d = DONE;
          rdy_d   = 1'b1;
          if (op_q) mem_we  = 1'b1;       // commit now so a following read sees it
          else      rdata_d = mem[addr_q];
        end
      end
      DONE: begin
        // Turnaround cycle: requests are deliberately not sampled here.
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      rdy_q   <= 1'b0;
      rdata_q <= 64'd0;
      addr_q  <= '0;
      op_q    <= 1'b0;
      wdata_q <= 64'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdy_q   <= rdy_d;
      rdata_q <= rdata_d;
      addr_q  <= addr_d;
      op_q    <= op_d;
      wdata_q <= wdata_d;
    end
  end

  // Array write port; no reset so contents persist. A write aborted by
  // reset never reaches this point because reset forces state_q to IDLE.
  always_ff @(posedge clk) begin
    if (mem_we) mem[addr_q] <= wdata_q;
  end

  assign bus.rdata = rdata_q;
  assign bus.rdy   = rdy_q;

`ifdef UMEM_ERR_EN
  logic err_q, err_d;

  // Flags ambiguous requests at accept, and a requester that drops or
  // changes its request while the memory is still busy.
  always_comb begin
    err_d = err_q;
    if (state_q == IDLE && bus.re && bus.we)
      err_d = 1'b1;
    if (state_q == BUSY && (!(bus.re || bus.we) || bus.addr != addr_q))
      err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= err_d;
  end

  assign err = err_q;
`endif

endmodule
